muldiv_seq_core: RTL and testbench
==================================

Name: muldiv_seq_core

Overview:
- Parametrised sequential arithmetic core built around a combined {A, Q, Q-1} shift register.
- Performs signed radix-2 Booth multiplication or unsigned restoring division on DW-bit operands, one iteration per clock.
- Sits between the operand/opcode registers and the result display/UART path.
- Replaces the fixed-width combinational register-mixing stage with a self-sequenced engine that has a start/done handshake, a divide-by-zero flag and a busy indication.

Parameters:
- DW, 8, operand width in bits (legal 4..32).
- CW, $clog2(DW)+1, iteration-counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = signed multiply, 1 = unsigned divide; captured with start.
- a  input  DW  multiplicand (mul) / dividend (div).
- b  input  DW  multiplier (mul) / divisor (div).
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- product  output  2*DW  signed product (mul); zero after a div.
- quotient  output  DW  quotient (div); zero after a mul.
- remainder  output  DW  remainder (div); zero after a mul.
- div_zero  output  1  set with done when op=1 and b=0; cleared on next accepted start.

Behaviour:
- Reset (asynchronous, rst=0): FSM to IDLE; all outputs, datapath and counter to 0. Applies immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- FSM states and transitions:
  - IDLE: start=1 at a clock edge -> capture a, b, op; go to RUN. Counter = 0.
  - Divide with b=0 -> go directly to DONE instead of RUN.
  - RUN: one iteration per edge; counter increments. At the edge where counter==DW-1 the final iteration is performed and state -> DONE.
  - DONE: done=1 and busy=1 for exactly one cycle. Next edge -> IDLE unconditionally.
- Latency: done is high in the cycle following the DW-th edge after the accepting edge (DW+1 cycles total for DW=8 -> 9 edges incl. accept). Divide-by-zero: done in the cycle after the accepting edge.
- start while not in IDLE is ignored. Operands and op may change freely after acceptance.
- Multiply (Booth, op=0):
  - Registers: A (DW+1 bits, init 0), Q = a, Q-1 = 0, M = sign-extended b (DW+1).
  - Each iteration: {Q0,Q-1}=01 -> A+=M; 10 -> A-=M; 00/11 -> no add. Then arithmetic right shift of {A,Q,Q-1} by 1.
  - product = low 2*DW bits of {A,Q}. Correct for every operand pair, including most-negative x most-negative.
- Divide (restoring, op=1, unsigned):
  - Registers: R (DW+1 bits, init 0), Q = a, D = zero-extended b.
  - Each iteration: shift {R,Q} left 1; R -= D. If R MSB=1, restore R += D and set Q0=0; else Q0=1.
  - quotient = Q; remainder = R[DW-1:0].
- Divide by zero: quotient = all-ones, remainder = a, div_zero = 1.
- Output registers: load at the RUN->DONE (or IDLE->DONE) edge and hold until the next accepted start. On acceptance, outputs are not cleared; div_zero clears at acceptance.

Decomposition:
- Pkg_Global gains:
  - parameterised typedef helpers for DW, 2*DW and DW+1 words;
  - enum typedef state_e {IDLE, RUN, DONE};
  - localparams OP_MUL=1'b0 and OP_DIV=1'b1.
- One sub-module, muldiv_step: combinational single iteration taking op, {A/R, Q, Q-1} and M/D, returning the next register value.
- muldiv_seq_core holds the FSM, counter, operand capture and output registers.

Test Plan (DW=8):
- Multiply: a=7, b=-3 (8'hFD), op=0, start 1 cycle -> done 8 edges after accept; product=16'hFFEB; quotient=0, remainder=0, div_zero=0.
- Multiply: a=8'h80, b=8'h80 -> product=16'h4000. Then a=8'h7F, b=8'h80 -> product=16'hC080.
- Divide: a=200, b=7, op=1 -> quotient=28 (8'h1C), remainder=4, div_zero=0, done after 8 edges.
- Divide by zero: a=5, b=0, op=1 -> done the cycle after accept; quotient=8'hFF, remainder=8'h05, div_zero=1. Next accepted start clears div_zero.
- Handshake: start held high continuously, operands changed every cycle -> only one operation per IDLE visit; results match operands at the accepting edge; busy high RUN..DONE; done exactly 1 cycle wide.
- Reset mid-run: assert rst=0 asynchronously at iteration 4 of 200/7 -> all outputs 0 immediately; no done; after release, a new start computes correctly.

Source files
------------

// File: rtl/muldiv_seq_core_pkg.sv
// Shared types and constants for the sequential Booth multiply / restoring divide core.
// Word types depend on the DW parameter, so each module declares its own.
package muldiv_seq_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_seq_core_step.sv
// One combinational iteration of the {A/R, Q, Q-1} register.
// Performs a radix-2 Booth multiply step or a restoring divide step.
module muldiv_step
  import muldiv_seq_core_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          op_i,
  input  logic [DW:0]   acc_i,
  input  logic [DW-1:0] q_i,
  input  logic          qm1_i,
  input  logic [DW:0]   opnd_i,
  output logic [DW:0]   acc_o,
  output logic [DW-1:0] q_o,
  output logic          qm1_o
);

  typedef logic [DW:0] ext_t;

  ext_t sum;
  ext_t rs;
  ext_t diff;

  always_comb begin
    sum   = acc_i;
    rs    = '0;
    diff  = '0;
    acc_o = acc_i;
    q_o   = q_i;
    qm1_o = qm1_i;
    if (op_i == OP_MUL) begin
      case ({q_i[0], qm1_i})
        2'b01:   sum = acc_i + opnd_i;
        2'b10:   sum = acc_i - opnd_i;
        default: sum = acc_i;
      endcase
      // Arithmetic right shift of the whole {A,Q,Q-1} chain.
      acc_o = {sum[DW], sum[DW:1]};
      q_o   = {sum[0], q_i[DW-1:1]};
      qm1_o = q_i[0];
    end else begin
      rs   = {acc_i[DW-1:0], q_i[DW-1]};
      diff = rs - opnd_i;
      if (diff[DW]) begin
        acc_o = rs;
        q_o   = {q_i[DW-2:0], 1'b0};
      end else begin
        acc_o = diff;
        q_o   = {q_i[DW-2:0], 1'b1};
      end
      qm1_o = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_seq_core.sv
// Self-sequenced signed multiply / unsigned divide engine with start/done handshake.
// One iteration per clock; results held in output registers until the next start.
module muldiv_seq_core
  import muldiv_seq_core_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero
);

  typedef logic [DW-1:0]   word_t;
  typedef logic [2*DW-1:0] dword_t;
  typedef logic [DW:0]     ext_t;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          op_q;
  ext_t          acc_q, acc_d;
  word_t         q_q, q_d;
  logic          qm1_q, qm1_d;
  ext_t          m_q;
  logic          busy_q, done_q, div_zero_q;
  dword_t        prod_q;
  word_t         quot_q, rem_q;

  muldiv_step #(.DW(DW)) u_step (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .q_i    (q_q),
    .qm1_i  (qm1_q),
    .opnd_i (m_q),
    .acc_o  (acc_d),
    .q_o    (q_d),
    .qm1_o  (qm1_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      acc_q      <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      prod_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q       <= op;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            if (op == OP_DIV && b == '0) begin
              // No iterations needed: publish the divide-by-zero result at once.
              state_q    <= DONE;
              done_q     <= 1'b1;
              prod_q     <= '0;
              quot_q     <= '1;
              rem_q      <= a;
              div_zero_q <= 1'b1;
            end else begin
              state_q <= RUN;
              acc_q   <= '0;
              q_q     <= a;
              qm1_q   <= 1'b0;
              m_q     <= (op == OP_MUL) ? {b[DW-1], b} : {1'b0, b};
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (op_q == OP_MUL) begin
              prod_q <= {acc_d[DW-1:0], q_d};
              quot_q <= '0;
              rem_q  <= '0;
            end else begin
              prod_q <= '0;
              quot_q <= q_d;
              rem_q  <= acc_d[DW-1:0];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = prod_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq_core.sv
// Directed bench for muldiv_seq_core at DW=8: multiply, divide, divide-by-zero,
// continuous-start handshake and asynchronous reset in mid-operation.
module tb_muldiv_seq_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [7:0]  a, b;
  logic        busy, done, div_zero;
  logic [15:0] product;
  logic [7:0]  quotient, remainder;

  int checks = 0;
  int errors = 0;
  int lat;
  int ndone;

  muldiv_seq_core #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, scramble inputs after acceptance, then wait for done.
  // lat counts edges after the accepting edge until done is visible.
  task automatic run_op(input logic o, input logic [7:0] aa, input logic [7:0] bb);
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; op = ~o; a = 8'h55; b = 8'h33;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_done_drops(input string tag);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_quot_rem", {16'd0, quotient, remainder}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 7 * -3 = -21
    run_op(1'b0, 8'd7, 8'hFD);
    check("mul1_latency", lat, 8);
    check("mul1_product", {16'd0, product}, 32'h0000_FFEB);
    check("mul1_quot_rem", {16'd0, quotient, remainder}, 32'd0);
    check("mul1_div_zero", {31'd0, div_zero}, 32'd0);
    check("mul1_busy_in_done", {31'd0, busy}, 32'd1);
    check_done_drops("mul1");

    // -128 * -128 = 16384
    run_op(1'b0, 8'h80, 8'h80);
    check("mul2_product", {16'd0, product}, 32'h0000_4000);

    // 127 * -128 = -16256
    run_op(1'b0, 8'h7F, 8'h80);
    check("mul3_product", {16'd0, product}, 32'h0000_C080);
    check_done_drops("mul3");

    // 200 / 7 = 28 rem 4
    run_op(1'b1, 8'd200, 8'd7);
    check("div1_latency", lat, 8);
    check("div1_quotient", {24'd0, quotient}, 32'h1C);
    check("div1_remainder", {24'd0, remainder}, 32'h04);
    check("div1_product", {16'd0, product}, 32'd0);
    check("div1_div_zero", {31'd0, div_zero}, 32'd0);
    check_done_drops("div1");

    // 5 / 0
    run_op(1'b1, 8'd5, 8'd0);
    check("div0_latency", lat, 0);
    check("div0_quotient", {24'd0, quotient}, 32'hFF);
    check("div0_remainder", {24'd0, remainder}, 32'h05);
    check("div0_flag", {31'd0, div_zero}, 32'd1);
    check("div0_product", {16'd0, product}, 32'd0);
    check_done_drops("div0");
    check("div0_flag_held", {31'd0, div_zero}, 32'd1);

    // Next accepted start clears div_zero but leaves result registers untouched.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'd7; b = 8'hFD;
    @(negedge clk);
    start = 1'b0;
    check("clr_div_zero", {31'd0, div_zero}, 32'd0);
    check("clr_quot_held", {24'd0, quotient}, 32'hFF);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("clr_latency", lat, 8);
    check("clr_product", {16'd0, product}, 32'h0000_FFEB);
    check("clr_quotient", {24'd0, quotient}, 32'd0);

    // start held high for 20 cycles while operands change every cycle.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd5;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("hs_busy", {31'd0, busy}, (i == 10 || i == 20) ? 32'd0 : 32'd1);
      check("hs_done", {31'd0, done}, (i == 9 || i == 19) ? 32'd1 : 32'd0);
      if (done) ndone++;
      if (i == 9)  check("hs_product1", {16'd0, product}, 32'h0000_000F);
      if (i == 19) check("hs_product2", {16'd0, product}, 32'h0000_006E);
      a = i[7:0];
      b = 8'(i + 1);
    end
    start = 1'b0;
    check("hs_done_count", ndone, 2);

    // Asynchronous reset during the fourth iteration of 200 / 7.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'd200; b = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_product", {16'd0, product}, 32'd0);
    check("mrst_quot_rem", {16'd0, quotient, remainder}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_no_done", ndone, 0);
    check("mrst_idle", {31'd0, busy}, 32'd0);

    run_op(1'b1, 8'd200, 8'd7);
    check("post_rst_latency", lat, 8);
    check("post_rst_quotient", {24'd0, quotient}, 32'h1C);
    check("post_rst_remainder", {24'd0, remainder}, 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
